estimador_mux_sched: RTL
========================

Name: estimador_mux_sched

Overview:
- Scheduler that shares one 3:1 21-bit operand mux and the fixed-latency arithmetic unit behind it among three estimator channels (e.g. i_d, i_q, speed).
- Accepts one request per cycle, by round-robin or fixed priority.
- Drives the 2-bit mux select code and an issue strobe to the unit.
- Tracks which channel owns each in-flight result and returns every result to its requester.

Parameters:
- DW, 21: operand/result width (fixed-point word).
- LATENCY, 4: cycles from issue to valid result at the unit output; legal range 1..15.

Ports:
- ap_clk, in, 1: clock, rising edge.
- ap_rst_n, in, 1: asynchronous active-low reset.
- req_vld, in, 3: per-channel request valid; bit i = channel i.
- req_rdy, out, 3: per-channel grant; one-hot or zero.
- prio_mode, in, 1: 0 = round-robin, 1 = fixed priority ch0 > ch1 > ch2.
- mux_sel, out, 2: select to the shared mux: 00 = ch0, 01 = ch1, 10 = ch2.
- unit_rdy, in, 1: shared unit may accept an issue this cycle.
- unit_vld, out, 1: issue strobe to the shared unit.
- unit_res, in, DW: result from the shared unit, valid exactly LATENCY cycles after its issue.
- res_dat, out, DW: registered result.
- res_vld, out, 3: registered one-hot result strobe for the owning channel.
- busy, out, 1: any request pending or any result in flight.

Behaviour:
- Reset (asynchronous, while ap_rst_n = 0):
  - res_dat = 0, res_vld = 000.
  - Round-robin pointer ptr = 0.
  - Tag pipeline cleared (all valid bits 0); in-flight counter = 0.
  - Combinational outputs follow from the cleared state: req_rdy = 000, unit_vld = 0, mux_sel = 00, busy = |req_vld.
- Grant (combinational, same cycle):
  - If unit_rdy = 0 or req_vld = 000: grant = 000.
  - Otherwise, round-robin mode: search channels ptr, ptr+1, ptr+2 (mod 3) and grant the first requesting channel.
  - Otherwise, fixed mode: grant the lowest-index requesting channel.
- Issue: req_rdy = grant; unit_vld = |grant; mux_sel = encoded grant, or 00 when there is no grant.
- A handshake on channel i is req_vld[i] & req_rdy[i]. The requester must hold its operand stable on the mux input during that cycle only.
- Pointer update:
  - Only on a round-robin-mode grant to channel k: ptr <= (k+1) mod 3, so 2 wraps to 0.
  - Unchanged when there is no grant or in fixed mode.
  - Switching prio_mode takes effect in the same cycle; ptr keeps its value.
- Tag pipeline:
  - LATENCY-stage shift register of {valid, ch[1:0]}; stage 0 is loaded with {unit_vld, grant index} every cycle.
  - At the output stage with valid = 1 and ch = c: res_dat <= unit_res, res_vld <= onehot(c) on the next edge.
  - End-to-end latency from handshake edge to res_vld is LATENCY+1 cycles.
  - res_vld is a one-cycle pulse per result; res_dat holds its value when res_vld = 000.
- In-flight counter:
  - +1 on issue, -1 on result retire; both in the same cycle leaves it unchanged.
  - Maximum value is LATENCY; counter width is clog2(LATENCY+1).
- busy = (|req_vld) | (counter != 0).
- Throughput: one issue per cycle, with no bubbles between back-to-back grants.
- Results are never back-pressured; requesters must always accept res_vld.
- Reset mid-operation: all in-flight tags are discarded; no res_vld is produced for issues made before reset.
- ch code 11 never enters the pipeline.

Decomposition:
- Shared package estimador_sched_pkg:
  - NCH = 3.
  - Select constants SEL_CH0 = 2'b00, SEL_CH1 = 2'b01, SEL_CH2 = 2'b10.
  - Tag struct {vld, ch[1:0]}.
  - Function onehot_to_sel.
- One sub-module, estimador_tag_pipe: a parameterised LATENCY-deep delay line of tags with asynchronous active-low clear.

Test Plan:
- Reset: hold ap_rst_n = 0 with req_vld = 111 and unit_rdy = 1 -> req_rdy = 000, unit_vld = 0, res_vld = 000, res_dat = 0, mux_sel = 00, busy = 1. Then release reset with req_vld = 000 -> busy = 0.
- Round-robin saturation: req_vld = 111, unit_rdy = 1, prio_mode = 0, LATENCY = 4, unit_res = issue cycle index -> grants 001, 010, 100, 001…; mux_sel 00, 01, 10, 00…; first res_vld = 001 at 5 cycles after the first handshake edge, then 010, 100 on consecutive cycles with matching res_dat.
- Fixed priority: req_vld = 111, prio_mode = 1 for 6 cycles -> req_rdy = 001 every cycle and ptr unchanged. Then drop req_vld[0] -> req_rdy = 010.
- Stall: unit_rdy = 0 for 3 cycles with req_vld = 110 -> req_rdy = 000, unit_vld = 0, ptr held. Then unit_rdy = 1 with ptr = 0 -> grant 010 first, then 100.
- Single requester wrap: req_vld = 100 continuously -> grant 100 every cycle, ptr = 0 after each grant, one res_vld = 100 per cycle at steady state.
- Reset mid-flight: issue 3 requests, assert ap_rst_n = 0 one cycle later for 1 cycle -> no res_vld for any of the 3; counter = 0 and busy = 0 once req_vld = 000.

Source files
------------

// File: rtl/estimador_sched_pkg.sv
// Shared types and constants for the estimator mux scheduler.
// Channel select codes, the in-flight tag and the grant encoder live here.
package estimador_sched_pkg;

    localparam int NCH = 3;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;

    typedef struct packed {
        logic       vld;
        logic [1:0] ch;
    } tag_t;

    // A zero grant encodes to SEL_CH0, so the mux idles on channel 0.
    function automatic logic [1:0] onehot_to_sel(input logic [NCH-1:0] oh);
        if (oh[1])      return SEL_CH1;
        else if (oh[2]) return SEL_CH2;
        else            return SEL_CH0;
    endfunction

endpackage

// File: rtl/estimador_tag_pipe.sv
// Delay line carrying the owner tag of each issue alongside the shared unit.
// Stage LATENCY-1 lines up with the cycle in which the unit presents the result.
module estimador_tag_pipe
    import estimador_sched_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stg_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign tag_o = stg_q[LATENCY-1];

endmodule

// File: rtl/estimador_mux_sched.sv
// Arbitrates three estimator channels onto one shared operand mux and
// fixed-latency unit, and steers each result back to its owner.
module estimador_mux_sched
    import estimador_sched_pkg::*;
#(
    parameter int DW      = 21,
    parameter int LATENCY = 4
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic [2:0]    req_vld,
    output logic [2:0]    req_rdy,
    input  logic          prio_mode,
    output logic [1:0]    mux_sel,
    input  logic          unit_rdy,
    output logic          unit_vld,
    input  logic [DW-1:0] unit_res,
    output logic [DW-1:0] res_dat,
    output logic [2:0]    res_vld,
    output logic          busy
);

    localparam int CW = $clog2(LATENCY + 1);

    logic [1:0]    ptr_q, ptr_d;
    logic [2:0]    grant;
    logic [1:0]    gsel;
    logic [2:0]    sum;
    logic [1:0]    idx;
    logic          found;
    logic [DW-1:0] res_dat_q, res_dat_d;
    logic [2:0]    res_vld_q, res_vld_d;
    logic [CW-1:0] cnt_q, cnt_d;
    tag_t          tag_in, tag_out;

    // Grant is held off during reset so nothing is issued from a cleared state.
    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        if (ap_rst_n && unit_rdy && (|req_vld)) begin
            if (prio_mode) begin
                if (req_vld[0])      grant = 3'b001;
                else if (req_vld[1]) grant = 3'b010;
                else                 grant = 3'b100;
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    sum = {1'b0, ptr_q} + 3'(i);
                    idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                    if (!found && req_vld[idx]) begin
                        grant[idx] = 1'b1;
                        found      = 1'b1;
                    end
                end
            end
        end
    end

    assign gsel     = onehot_to_sel(grant);
    assign req_rdy  = grant;
    assign unit_vld = |grant;
    assign mux_sel  = gsel;

    always_comb begin
        ptr_d = ptr_q;
        if (!prio_mode && (|grant)) ptr_d = (gsel == SEL_CH2) ? SEL_CH0 : gsel + 2'd1;
    end

    assign tag_in = '{vld: unit_vld, ch: gsel};

    estimador_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    always_comb begin
        res_vld_d = '0;
        res_dat_d = res_dat_q;
        if (tag_out.vld) begin
            res_vld_d = 3'b001 << tag_out.ch;
            res_dat_d = unit_res;
        end
    end

    // Issue and retire in the same cycle cancel out.
    always_comb begin
        cnt_d = cnt_q;
        case ({unit_vld, tag_out.vld})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q     <= SEL_CH0;
            res_dat_q <= '0;
            res_vld_q <= '0;
            cnt_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            res_dat_q <= res_dat_d;
            res_vld_q <= res_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign res_dat = res_dat_q;
    assign res_vld = res_vld_q;
    assign busy    = (|req_vld) | (cnt_q != '0);

endmodule
